// File: rtl/icache_dm_responder_if.sv
// Fetch-port and backing-memory signals of the direct-mapped instruction cache.
// Signal directions in the names are as seen from the cache.
interface icache_dm_responder_if;
  logic        i_IC_DataReq;
  logic [31:0] i_IC_Addr;
  logic        o_IC_MemReady;
  logic [31:0] o_IC_Instr;
  logic        i_flush;
  logic        o_MEM_Req;
  logic [31:0] o_MEM_Addr;
  logic        i_MEM_Ready;
  logic [31:0] i_MEM_Data;

  // Cache side
  modport slave (
    input  i_IC_DataReq, i_IC_Addr, i_flush, i_MEM_Ready, i_MEM_Data,
    output o_IC_MemReady, o_IC_Instr, o_MEM_Req, o_MEM_Addr
  );

  // Hart plus backing-memory side
  modport master (
    output i_IC_DataReq, i_IC_Addr, i_flush, i_MEM_Ready, i_MEM_Data,
    input  o_IC_MemReady, o_IC_Instr, o_MEM_Req, o_MEM_Addr
  );
endinterface

// File: rtl/icache_dm_responder.sv
// Direct-mapped read-only instruction cache. Hits answer after one cycle; misses
// refill the whole line word 0 upward, then answer one cycle after the last word.
module icache_dm_responder #(
  parameter int unsigned NLINES         = 64,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input logic                  i_clk,
  input logic                  i_rst,
  icache_dm_responder_if.slave bus
);
  localparam int unsigned OFF_W = $clog2(WORDS_PER_LINE);
  localparam int unsigned IDX_W = $clog2(NLINES);
  localparam int unsigned TAG_W = 30 - OFF_W - IDX_W;

  typedef enum logic [1:0] {StIdle, StRefill, StResp} state_e;

  state_e r_state, w_state_d;

  logic [NLINES-1:0] r_valid;
  logic [TAG_W-1:0]  r_tagmem [NLINES];
  logic [31:0]       r_data   [NLINES*WORDS_PER_LINE];

  logic [TAG_W-1:0] r_tag;
  logic [IDX_W-1:0] r_idx;
  logic [OFF_W-1:0] r_off;
  logic [OFF_W-1:0] r_cnt;
  logic             r_flushed;   // a flush arrived during this fill
  logic             r_req_lost;  // hart dropped its request during this fill
  logic             r_ready;
  logic [31:0]      r_instr;
  logic             r_mem_req;
  logic [31:0]      r_mem_addr;

  logic [OFF_W-1:0] w_off;
  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_hit;
  logic             w_fill_word;
  logic             w_fill_last;
  logic             w_req_ok;
  logic             w_unused;

  assign w_off = bus.i_IC_Addr[OFF_W+1:2];
  assign w_idx = bus.i_IC_Addr[IDX_W+OFF_W+1:OFF_W+2];
  assign w_tag = bus.i_IC_Addr[31:IDX_W+OFF_W+2];
  assign w_unused = ^bus.i_IC_Addr[1:0];

  // A flush coinciding with a request forces the miss path
  assign w_hit = r_valid[w_idx] && (r_tagmem[w_idx] == w_tag) && !bus.i_flush;

  assign w_fill_word = (r_state == StRefill) && bus.i_MEM_Ready;
  assign w_fill_last = w_fill_word && (r_cnt == OFF_W'(WORDS_PER_LINE - 1));
  assign w_req_ok    = bus.i_IC_DataReq && !r_req_lost;

  assign bus.o_IC_MemReady = r_ready;
  assign bus.o_IC_Instr    = r_instr;
  assign bus.o_MEM_Req     = r_mem_req;
  assign bus.o_MEM_Addr    = r_mem_addr;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  // Next-state decode
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (bus.i_IC_DataReq) w_state_d = w_hit ? StResp : StRefill;
      end
      StRefill: begin
        if (w_fill_last) w_state_d = w_req_ok ? StResp : StIdle;
      end
      StResp:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Response, miss bookkeeping and backing-request datapath
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ready    <= 1'b0;
      r_instr    <= '0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_tag      <= '0;
      r_idx      <= '0;
      r_off      <= '0;
      r_cnt      <= '0;
      r_flushed  <= 1'b0;
      r_req_lost <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_ready <= 1'b0;
          if (bus.i_IC_DataReq) begin
            if (w_hit) begin
              r_instr <= r_data[{w_idx, w_off}];
              r_ready <= 1'b1;
            end else begin
              r_tag      <= w_tag;
              r_idx      <= w_idx;
              r_off      <= w_off;
              r_cnt      <= '0;
              r_flushed  <= 1'b0;
              r_req_lost <= 1'b0;
              r_mem_req  <= 1'b1;
              r_mem_addr <= {w_tag, w_idx, {OFF_W{1'b0}}, 2'b00};
            end
          end
        end
        StRefill: begin
          if (!bus.i_IC_DataReq) r_req_lost <= 1'b1;
          if (bus.i_flush)       r_flushed  <= 1'b1;
          if (bus.i_MEM_Ready) begin
            r_cnt      <= r_cnt + OFF_W'(1);
            r_mem_addr <= r_mem_addr + 32'd4;
            if (r_cnt == r_off) r_instr <= bus.i_MEM_Data;
            if (w_fill_last) begin
              r_mem_req <= 1'b0;
              r_ready   <= w_req_ok;
            end
          end
        end
        StResp:  r_ready <= 1'b0;
        default: r_ready <= 1'b0;
      endcase
    end
  end

  // Valid bits; flush wins over the fill that completes on the same edge
  always_ff @(posedge i_clk) begin
    if (i_rst || bus.i_flush) r_valid <= '0;
    else if (w_fill_last && !r_flushed) r_valid[r_idx] <= 1'b1;
  end

  // Tag and data arrays carry no reset; valid bits gate their use
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_fill_word) begin
      r_data[{r_idx, r_cnt}] <= bus.i_MEM_Data;
      if (w_fill_last) r_tagmem[r_idx] <= r_tag;
    end
  end
endmodule

// File: tb/tb_icache_dm_responder.sv
// Directed bench for icache_dm_responder: hits, misses, conflicts, flushes, reset.
module tb_icache_dm_responder;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  icache_dm_responder_if bus ();

  icache_dm_responder #(
    .NLINES        (64),
    .WORDS_PER_LINE(4)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Backing memory answers one word dly cycles after the request is seen
  task automatic serve_word(input string tag, input logic [31:0] exp_addr,
                            input logic [31:0] data, input int dly, input bit fl);
    chk({tag, ".mem_req"}, {31'b0, bus.o_MEM_Req}, 32'd1);
    chk({tag, ".mem_addr"}, bus.o_MEM_Addr, exp_addr);
    repeat (dly - 1) @(negedge clk);
    bus.i_MEM_Ready = 1'b1;
    bus.i_MEM_Data  = data;
    bus.i_flush     = fl;
    @(negedge clk);
    bus.i_MEM_Ready = 1'b0;
    bus.i_MEM_Data  = '0;
    bus.i_flush     = 1'b0;
  endtask

  task automatic fetch_miss(input string tag, input logic [31:0] addr, input logic [31:0] base,
                            input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input logic [31:0] w3,
                            input logic [31:0] exp, input int dly, input int flush_word);
    bus.i_IC_DataReq = 1'b1;
    bus.i_IC_Addr    = addr;
    @(negedge clk);
    serve_word({tag, ".w0"}, base,          w0, dly, flush_word == 0);
    serve_word({tag, ".w1"}, base + 32'h4,  w1, dly, flush_word == 1);
    serve_word({tag, ".w2"}, base + 32'h8,  w2, dly, flush_word == 2);
    serve_word({tag, ".w3"}, base + 32'hC,  w3, dly, flush_word == 3);
    chk({tag, ".ready"}, {31'b0, bus.o_IC_MemReady}, 32'd1);
    chk({tag, ".instr"}, bus.o_IC_Instr, exp);
    chk({tag, ".req_drop"}, {31'b0, bus.o_MEM_Req}, 32'd0);
    bus.i_IC_DataReq = 1'b0;
    @(negedge clk);
    chk({tag, ".ready_pulse"}, {31'b0, bus.o_IC_MemReady}, 32'd0);
  endtask

  task automatic fetch_hit(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    bus.i_IC_DataReq = 1'b1;
    bus.i_IC_Addr    = addr;
    @(negedge clk);
    chk({tag, ".ready"}, {31'b0, bus.o_IC_MemReady}, 32'd1);
    chk({tag, ".instr"}, bus.o_IC_Instr, exp);
    chk({tag, ".mem_req"}, {31'b0, bus.o_MEM_Req}, 32'd0);
    bus.i_IC_DataReq = 1'b0;
    @(negedge clk);
    chk({tag, ".ready_pulse"}, {31'b0, bus.o_IC_MemReady}, 32'd0);
    chk({tag, ".instr_hold"}, bus.o_IC_Instr, exp);
  endtask

  initial begin
    rst              = 1'b1;
    bus.i_IC_DataReq = 1'b0;
    bus.i_IC_Addr    = '0;
    bus.i_flush      = 1'b0;
    bus.i_MEM_Ready  = 1'b0;
    bus.i_MEM_Data   = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset.ready", {31'b0, bus.o_IC_MemReady}, 32'd0);
    chk("reset.instr", bus.o_IC_Instr, 32'd0);
    chk("reset.mem_req", {31'b0, bus.o_MEM_Req}, 32'd0);
    chk("reset.mem_addr", bus.o_MEM_Addr, 32'd0);

    // Cold miss, backing word 2 cycles after each request
    fetch_miss("miss100", 32'h100, 32'h100, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA0, 2, -1);
    // Hits on the freshly filled line, including its last word
    fetch_hit("hit108", 32'h108, 32'hA2);
    fetch_hit("hit10C", 32'h10C, 32'hA3);

    // Conflict on index 0x10, then the evicted line refills
    fetch_miss("miss500", 32'h504, 32'h500, 32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hB1, 1, -1);
    fetch_hit("hit50C", 32'h50C, 32'hB3);
    fetch_miss("remiss100", 32'h100, 32'h100, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA0, 3, -1);

    // Flush in idle invalidates the line
    bus.i_flush = 1'b1;
    @(negedge clk);
    bus.i_flush = 1'b0;
    chk("flush.ready", {31'b0, bus.o_IC_MemReady}, 32'd0);
    fetch_miss("flushmiss104", 32'h104, 32'h100, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA1, 1, -1);
    fetch_hit("hit104", 32'h104, 32'hA1);

    // Flush during the 2nd refill word: response still delivered, line stays invalid
    fetch_miss("flushfill208", 32'h208, 32'h200, 32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'hC2, 1, 1);
    fetch_miss("remiss200", 32'h200, 32'h200, 32'hD0, 32'hD1, 32'hD2, 32'hD3, 32'hD0, 1, -1);
    // Flush on the last word edge: flush wins, response still delivered
    bus.i_flush = 1'b1;
    @(negedge clk);
    bus.i_flush = 1'b0;
    fetch_miss("flushlast20C", 32'h20C, 32'h200, 32'hE0, 32'hE1, 32'hE2, 32'hE3, 32'hE3, 1, 3);
    fetch_miss("remiss204", 32'h204, 32'h200, 32'hF0, 32'hF1, 32'hF2, 32'hF3, 32'hF1, 1, -1);

    // Reset after two refill words abandons the fill
    bus.i_IC_DataReq = 1'b1;
    bus.i_IC_Addr    = 32'h300;
    @(negedge clk);
    serve_word("rst300.w0", 32'h300, 32'h30, 1, 1'b0);
    serve_word("rst300.w1", 32'h304, 32'h31, 1, 1'b0);
    rst              = 1'b1;
    bus.i_IC_DataReq = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst300.mem_req", {31'b0, bus.o_MEM_Req}, 32'd0);
    chk("rst300.ready", {31'b0, bus.o_IC_MemReady}, 32'd0);
    chk("rst300.instr", bus.o_IC_Instr, 32'd0);
    @(negedge clk);
    chk("rst300.idle_ready", {31'b0, bus.o_IC_MemReady}, 32'd0);
    fetch_miss("remiss300", 32'h300, 32'h300, 32'h40, 32'h41, 32'h42, 32'h43, 32'h40, 1, -1);
    // Reset also cleared earlier valid lines
    fetch_miss("postrst100", 32'h108, 32'h100, 32'h50, 32'h51, 32'h52, 32'h53, 32'h52, 1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
